// File: rtl/averaging_sequencer.sv
// Sequencer driving a bank of averager channels: clears accumulators, issues
// interleaved per-channel add strobes for N sample slots, then publishes results.
module averaging_sequencer #(
    parameter int max_samples = 16,
    parameter int channels    = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               continuous,
    input  logic [$clog2(max_samples+1)-1:0]   sample_count,
    output logic [channels-1:0]                clear,
    output logic [channels-1:0]                add,
    output logic [channels-1:0]                show,
    output logic                               busy
);

    localparam int NW = $clog2(max_samples + 1);
    localparam int CW = (channels > 1) ? $clog2(channels) : 1;
    localparam logic [NW-1:0]       N_ZERO   = {NW{1'b0}};
    localparam logic [NW-1:0]       N_ONE    = NW'(1);
    localparam logic [NW-1:0]       N_MAX    = NW'(max_samples);
    localparam logic [CW-1:0]       C_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]       C_ONE    = CW'(1);
    localparam logic [CW-1:0]       C_LAST   = CW'(channels - 1);
    localparam logic [channels-1:0] ALL_ONES = {channels{1'b1}};
    localparam logic [channels-1:0] NONE     = {channels{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        ACQUIRE = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t          state_r;
    logic [NW-1:0]   n_r;
    logic [NW-1:0]   slot_r;
    logic [CW-1:0]   chan_r;
    logic            gap_r;
    logic            start_q_r;
    logic            hist_valid_r;
    logic            start_edge_s;

    function automatic logic [NW-1:0] clamp_n(input logic [NW-1:0] n);
        logic [NW-1:0] r;
        if (n == N_ZERO) begin
            r = N_ONE;
        end else if (n > N_MAX) begin
            r = N_MAX;
        end else begin
            r = n;
        end
        return r;
    endfunction

    function automatic logic [channels-1:0] one_hot(input logic [CW-1:0] c);
        logic [channels-1:0] r;
        r = NONE;
        for (int i = 0; i < channels; i++) begin
            if (CW'(i) == c) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Rising-edge detect; suppressed until one real history sample exists after reset
    always_comb begin
        start_edge_s = 1'b0;
        if (start && !start_q_r && hist_valid_r) begin
            start_edge_s = 1'b1;
        end else begin
            start_edge_s = 1'b0;
        end
    end

    // Main sequencer with registered strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            n_r          <= N_ZERO;
            slot_r       <= N_ZERO;
            chan_r       <= C_ZERO;
            gap_r        <= 1'b0;
            start_q_r    <= 1'b0;
            hist_valid_r <= 1'b0;
            clear        <= NONE;
            add          <= NONE;
            show         <= NONE;
            busy         <= 1'b0;
        end else begin
            start_q_r    <= start;
            hist_valid_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (start_edge_s) begin
                        n_r     <= clamp_n(sample_count);
                        state_r <= CLEAR;
                        clear   <= ALL_ONES;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                CLEAR: begin
                    clear   <= NONE;
                    state_r <= ACQUIRE;
                    slot_r  <= N_ZERO;
                    chan_r  <= C_ZERO;
                    gap_r   <= 1'b0;
                    add     <= one_hot(C_ZERO);
                end
                ACQUIRE: begin
                    if (!gap_r) begin
                        add   <= NONE;
                        gap_r <= 1'b1;
                    end else if (chan_r != C_LAST) begin
                        chan_r <= chan_r + C_ONE;
                        add    <= one_hot(chan_r + C_ONE);
                        gap_r  <= 1'b0;
                    end else if ((slot_r + N_ONE) != n_r) begin
                        // Slot finished for all channels; start the next one
                        slot_r <= slot_r + N_ONE;
                        chan_r <= C_ZERO;
                        add    <= one_hot(C_ZERO);
                        gap_r  <= 1'b0;
                    end else begin
                        state_r <= SHOW;
                        show    <= ALL_ONES;
                        gap_r   <= 1'b0;
                    end
                end
                SHOW: begin
                    show <= NONE;
                    if (continuous) begin
                        n_r     <= clamp_n(sample_count);
                        state_r <= CLEAR;
                        clear   <= ALL_ONES;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    clear   <= NONE;
                    add     <= NONE;
                    show    <= NONE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_averaging_sequencer.sv
// Directed bench for averaging_sequencer with channels=2, max_samples=16.
module tb_averaging_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       continuous;
    logic [4:0] sample_count;
    logic [1:0] clear;
    logic [1:0] add;
    logic [1:0] show;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int clear_cnt   = 0;
    int show_cnt    = 0;
    int add0_cnt    = 0;
    int add1_cnt    = 0;
    int overlap_cnt = 0;
    int c0, s0, a0, a1;

    always #5 clock = ~clock;

    averaging_sequencer #(.max_samples(16), .channels(2)) dut (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous),
        .sample_count(sample_count), .clear(clear), .add(add), .show(show), .busy(busy)
    );

    // Pulse tally, sampled away from the active edge
    always @(negedge clock) begin
        if (clear == 2'b11) clear_cnt++;
        if (show == 2'b11) show_cnt++;
        if (add[0]) add0_cnt++;
        if (add[1]) add1_cnt++;
        if (add == 2'b11) overlap_cnt++;
        if (((clear != 2'b00) ? 1 : 0) + ((add != 2'b00) ? 1 : 0) + ((show != 2'b00) ? 1 : 0) > 1)
            overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_clear"}, 32'(clear), 32'h0);
        check({tag, "_add"},   32'(add),   32'h0);
        check({tag, "_show"},  32'(show),  32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called on the negedge where the CLEAR cycle is visible; ends on the SHOW cycle
    task automatic run_check(input int n);
        logic [1:0] exp_add;
        check("run_clear", 32'(clear), 32'h3);
        check("run_clear_add", 32'(add), 32'h0);
        check("run_clear_show", 32'(show), 32'h0);
        check("run_clear_busy", 32'(busy), 32'h1);
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                exp_add = (i == 0) ? 2'b01 : ((i == 2) ? 2'b10 : 2'b00);
                check("acq_add", 32'(add), 32'(exp_add));
                check("acq_clear", 32'(clear), 32'h0);
                check("acq_show", 32'(show), 32'h0);
                check("acq_busy", 32'(busy), 32'h1);
            end
        end
        @(negedge clock);
        check("show", 32'(show), 32'h3);
        check("show_add", 32'(add), 32'h0);
        check("show_clear", 32'(clear), 32'h0);
        check("show_busy", 32'(busy), 32'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) @(negedge clock);
        check("idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        continuous   = 1'b0;
        sample_count = 5'd0;
        repeat (3) @(negedge clock);
        idle_check("in_reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        idle_check("post_reset");

        // Basic run, N=3: 14 busy cycles
        sample_count = 5'd3;
        pulse_start();
        run_check(3);
        @(negedge clock);
        idle_check("n3_end");

        // Clamp: 0 -> 1, 31 -> 16
        sample_count = 5'd0;
        pulse_start();
        run_check(1);
        @(negedge clock);
        idle_check("n0_end");
        sample_count = 5'd31;
        pulse_start();
        run_check(16);
        @(negedge clock);
        idle_check("n31_end");

        // Continuous back-to-back, then drop continuous during the third run
        continuous   = 1'b1;
        sample_count = 5'd2;
        pulse_start();
        run_check(2);
        @(negedge clock);
        run_check(2);
        @(negedge clock);
        continuous = 1'b0;
        run_check(2);
        @(negedge clock);
        idle_check("cont_end");

        // Held start gives one run only
        sample_count = 5'd1;
        start = 1'b1;
        @(negedge clock);
        run_check(1);
        for (int i = 0; i < 95; i++) begin
            @(negedge clock);
            check("held_busy", 32'(busy), 32'h0);
        end
        start = 1'b0;
        @(negedge clock);

        // Start edges while busy are ignored
        c0 = clear_cnt;
        s0 = show_cnt;
        sample_count = 5'd4;
        pulse_start();
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);
        check("one_run_clear", 32'(clear_cnt - c0), 32'd1);
        check("one_run_show", 32'(show_cnt - s0), 32'd1);
        check("one_run_busy", 32'(busy), 32'h0);

        // Reset mid-ACQUIRE with start held through reset
        sample_count = 5'd4;
        pulse_start();
        repeat (5) @(negedge clock);
        s0 = show_cnt;
        start = 1'b1;
        #2 reset = 1'b0;
        #1;
        idle_check("async_rst");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        idle_check("rst_release");
        check("rst_no_show", 32'(show_cnt - s0), 32'd0);
        start = 1'b0;
        @(negedge clock);
        pulse_start();
        run_check(4);
        @(negedge clock);
        idle_check("rst_rerun_end");

        // sample_count changes mid-run do not affect the latched N
        a0 = add0_cnt;
        a1 = add1_cnt;
        sample_count = 5'd3;
        pulse_start();
        repeat (4) @(negedge clock);
        sample_count = 5'd7;
        wait_idle();
        @(negedge clock);
        check("latched_add0", 32'(add0_cnt - a0), 32'd3);
        check("latched_add1", 32'(add1_cnt - a1), 32'd3);
        check("exclusive", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
